mem_stage_lsu: RTL

// - MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register; consumes its _M outputs.
// - Drives a req/gnt/rvalid data-memory bus, generates byte enables and store-data replication,

---
 rtl/mem_stage_lsu_if.sv | 21 ++
 rtl/mem_stage_lsu.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and the data memory (slave).
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one req/gnt/rvalid bus access per op, stalls the
// pipeline until it completes, and aligns/extends load data.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            ALUResult_M,
  input  logic [31:0]            writeData_M,
  input  logic [31:0]            instruction_M,
  input  logic                   memWrite_M,
  input  logic [1:0]             resultSrc_M,
  mem_stage_lsu_if.master        dmem,
  output logic [31:0]            load_data_M,
  output logic                   stall_M,
  output logic                   misaligned_M,
  output logic                   bus_err_M
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req, r_we, r_err;
  logic [31:0]      r_addr, r_wdata, r_ld;
  logic [3:0]       r_be;
  logic [1:0]       r_off;
  logic [2:0]       r_f3;

  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic        w_store, w_op, w_size_b, w_size_h, w_size_w, w_aligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_start, w_grant, w_rdone, w_timeout, w_expire;
  logic        w_unused_instr;

  function automatic logic [31:0] f_extend(input logic [31:0] rdata,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  f_extend = {{24{lane[7]}}, lane[7:0]};
      3'b100:  f_extend = {24'd0, lane[7:0]};
      3'b001:  f_extend = {{16{lane[15]}}, lane[15:0]};
      3'b101:  f_extend = {16'd0, lane[15:0]};
      default: f_extend = lane;
    endcase
  endfunction

  assign w_unused_instr = ^{instruction_M[31:15], instruction_M[11:0]};

  assign w_f3     = instruction_M[14:12];
  assign w_off    = ALUResult_M[1:0];
  assign w_store  = memWrite_M;
  assign w_op     = memWrite_M | (resultSrc_M == 2'b01);
  assign w_size_b = (w_f3 == 3'b000) || (w_f3 == 3'b100);
  assign w_size_h = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_size_w = !w_size_b && !w_size_h;
  assign w_aligned = w_size_w ? (w_off == 2'b00) : (w_size_h ? !w_off[0] : 1'b1);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = writeData_M;
    if (w_size_b) begin
      w_wdata = {4{writeData_M[7:0]}};
      if (w_store) w_be = 4'b0001 << w_off;
    end else if (w_size_h) begin
      w_wdata = {2{writeData_M[15:0]}};
      if (w_store) w_be = w_off[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_grant   = 1'b0;
    w_rdone   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_op && w_aligned) begin
          w_next  = S_REQ;
          w_start = 1'b1;
        end
      end
      S_REQ: begin
        if (dmem.dmem_gnt) begin
          w_grant = 1'b1;
          w_next  = r_we ? S_DONE : S_WAIT_R;
        end else if (w_expire) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_WAIT_R: begin
        if (dmem.dmem_rvalid) begin
          w_rdone = 1'b1;
          w_next  = S_DONE;
        end else if (w_expire) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Timeout counter: restarts when the request is issued and again when it is granted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_start || w_grant) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_WAIT_R) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_off   <= '0;
      r_f3    <= '0;
      r_ld    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= w_store;
        r_addr  <= {ALUResult_M[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_off   <= w_off;
        r_f3    <= w_f3;
      end else if (w_grant || w_timeout) begin
        r_req <= 1'b0;
      end
      if (w_rdone)        r_ld <= f_extend(dmem.dmem_rdata, r_off, r_f3);
      else if (w_timeout) r_ld <= '0;
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_wdata = r_wdata;

  assign load_data_M  = r_ld;
  assign bus_err_M    = r_err;
  // Combinational flags are masked while reset is asserted so every output reads 0.
  assign stall_M      = reset & w_op & w_aligned & (r_state != S_DONE);
  assign misaligned_M = reset & w_op & !w_aligned & (r_state == S_IDLE);

endmodule
